bandit_environment: RTL and testbench

- Stochastic multi-armed-bandit environment; the responder for the bandit agent's action/reward interface.
- Accepts an arm index on the action stream and returns a Bernoulli reward on the reward stream.
- Reward probability per arm comes from a software-loaded threshold table compared against a free-running LFSR.
- Sits opposite the agent in simulation and FPGA test harnesses, closing the learning loop.

---
 rtl/bandit_environment.sv | 100 ++++++++++
 tb/tb_bandit_environment.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bandit_environment.sv
// Bandit environment: takes one arm index at a time and answers with a
// Bernoulli reward. The reward probability comes from a software-loaded
// threshold table, compared against a free-running 16-bit Galois LFSR.
module bandit_environment #(
    parameter int          ACTION_WIDTH = 8,
    parameter int          REWARD_WIDTH = 16,
    parameter int          REWARD_VALUE = 255,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    action_valid,
    input  logic [ACTION_WIDTH-1:0] action_data,
    output logic                    action_ready,
    output logic                    reward_valid,
    output logic [REWARD_WIDTH-1:0] reward_data,
    input  logic                    reward_ready,
    input  logic                    config_write,
    input  logic [ACTION_WIDTH-1:0] config_address,
    input  logic [15:0]             config_data,
    output logic [31:0]             reward_count
);

    localparam int                      DEPTH      = 2 ** ACTION_WIDTH;
    localparam logic [REWARD_WIDTH-1:0] REWARD_HIT = REWARD_WIDTH'(REWARD_VALUE);
    localparam logic [15:0]             LFSR_MASK  = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESPOND
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q;
    logic [15:0]             thr_q;
    logic [REWARD_WIDTH-1:0] reward_data_q, reward_data_d;
    logic [31:0]             count_q, count_d;
    logic [15:0]             table_q [DEPTH];

    // One step of the right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Outputs decode straight from state; ready is also masked while reset is held.
    assign action_ready = (state_q == S_IDLE) && !reset;
    assign reward_valid = (state_q == S_RESPOND);
    assign reward_data  = reward_data_q;
    assign reward_count = count_q;

    // Next-state, reward decision and delivered-reward counting.
    always_comb begin
        state_d       = state_q;
        reward_data_d = reward_data_q;
        count_d       = count_q;
        case (state_q)
            S_IDLE: begin
                if (action_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                reward_data_d = (lfsr_q < thr_q) ? REWARD_HIT : '0;
                state_d       = S_RESPOND;
            end
            S_RESPOND: begin
                if (reward_ready) begin
                    state_d = S_IDLE;
                    if (reward_data_q != '0) count_d = count_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, reward register, counter and LFSR with async reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            reward_data_q <= '0;
            count_q       <= '0;
            lfsr_q        <= SEED;
        end else begin
            state_q       <= state_d;
            reward_data_q <= reward_data_d;
            count_q       <= count_d;
            lfsr_q        <= lfsr_step(lfsr_q);
        end
    end

    // Capture the arm's threshold on acceptance; a same-edge write is not seen (read-first).
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && action_valid) thr_q <= table_q[action_data];
    end

    // Threshold table writes, accepted in any state.
    always_ff @(posedge clock) begin
        if (config_write) table_q[config_address] <= config_data;
    end

endmodule

// File: tb/tb_bandit_environment.sv
// Directed bench for bandit_environment: vector table plus hand sequences
// for backpressure, same-edge config write, mid-transaction reset and a
// long statistical run checked against an LFSR reference model.
module tb_bandit_environment;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        action_valid = 1'b0;
    logic [7:0]  action_data = '0;
    logic        action_ready;
    logic        reward_valid;
    logic [15:0] reward_data;
    logic        reward_ready = 1'b0;
    logic        config_write = 1'b0;
    logic [7:0]  config_address = '0;
    logic [15:0] config_data = '0;
    logic [31:0] reward_count;

    int tests = 0;
    int fails = 0;
    int exp_count = 0;

    logic [15:0] m_lfsr;
    logic [15:0] tbl [256];

    bandit_environment #(
        .ACTION_WIDTH(8), .REWARD_WIDTH(16), .REWARD_VALUE(255), .SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset),
        .action_valid(action_valid), .action_data(action_data), .action_ready(action_ready),
        .reward_valid(reward_valid), .reward_data(reward_data), .reward_ready(reward_ready),
        .config_write(config_write), .config_address(config_address), .config_data(config_data),
        .reward_count(reward_count)
    );

    always #5 clock = ~clock;

    // Reference LFSR: Galois, mask B400, shift right, seeded on reset.
    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cfg(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        config_write = 1'b1; config_address = a; config_data = d;
        tbl[a] = d;
        @(negedge clock);
        config_write = 1'b0;
    endtask

    // Present an action, check acceptance and latency; returns at a negedge in RESPOND.
    task automatic send(input logic [7:0] arm, output logic [15:0] exp_d);
        @(negedge clock);
        action_valid = 1'b1; action_data = arm;
        chk("accept_ready", {31'd0, action_ready}, 32'd1);
        @(negedge clock);                       // past acceptance edge N
        action_valid = 1'b0;
        exp_d = (m_lfsr < tbl[arm]) ? 16'd255 : 16'd0;
        chk("lookup_valid_low", {31'd0, reward_valid}, 32'd0);
        @(negedge clock);                       // past edge N+1
        chk("resp_valid", {31'd0, reward_valid}, 32'd1);
        chk("resp_data", {16'd0, reward_data}, {16'd0, exp_d});
    endtask

    // Hold off reward_ready for `delay` cycles, then complete one handshake.
    task automatic finish_resp(input int delay, input logic [15:0] exp_d);
        for (int i = 0; i < delay; i++) begin
            chk("stall_valid", {31'd0, reward_valid}, 32'd1);
            chk("stall_data", {16'd0, reward_data}, {16'd0, exp_d});
            chk("stall_ready_low", {31'd0, action_ready}, 32'd0);
            @(negedge clock);
        end
        reward_ready = 1'b1;
        @(negedge clock);
        reward_ready = 1'b0;
        if (exp_d != 16'd0) exp_count++;
        chk("post_hs_valid", {31'd0, reward_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, action_ready}, 32'd1);
        chk("post_hs_count", reward_count, exp_count);
    endtask

    typedef struct {
        logic [7:0]  arm;
        logic [15:0] thr;
        int          delay;
        logic [15:0] exp_d;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [15:0] e;
        logic [15:0] e2;
        int          base;

        vecs[0] = '{8'd0,   16'h0000, 0, 16'd0};
        vecs[1] = '{8'd5,   16'hFFFF, 0, 16'd255};
        vecs[2] = '{8'd5,   16'hFFFF, 1, 16'd255};
        vecs[3] = '{8'd5,   16'hFFFF, 0, 16'd255};
        vecs[4] = '{8'd1,   16'h0001, 2, 16'd0};
        vecs[5] = '{8'd255, 16'hFFFF, 1, 16'd255};
        vecs[6] = '{8'd9,   16'h0000, 3, 16'd0};
        vecs[7] = '{8'd128, 16'hFFFF, 0, 16'd255};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, action_ready}, 32'd0);
        chk("rst_valid", {31'd0, reward_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", {31'd0, action_ready}, 32'd1);
        chk("idle_valid", {31'd0, reward_valid}, 32'd0);
        chk("idle_data", {16'd0, reward_data}, 32'd0);
        chk("idle_count", reward_count, 32'd0);

        // Vector table: thresholds 0 and 1 never reward, FFFF rewards unless lfsr is FFFF
        for (int i = 0; i < 8; i++) begin
            cfg(vecs[i].arm, vecs[i].thr);
            send(vecs[i].arm, e);
            if (e == vecs[i].exp_d) chk("vec_hand", {16'd0, reward_data}, {16'd0, vecs[i].exp_d});
            finish_resp(vecs[i].delay, e);
        end

        // Backpressure: 10 stalled cycles with ignored action pulses
        send(8'd5, e);
        for (int i = 0; i < 10; i++) begin
            action_valid = i[0]; action_data = 8'd0;
            chk("bp_valid", {31'd0, reward_valid}, 32'd1);
            chk("bp_data", {16'd0, reward_data}, {16'd0, e});
            chk("bp_ready", {31'd0, action_ready}, 32'd0);
            @(negedge clock);
        end
        action_valid = 1'b0;
        finish_resp(0, e);
        @(negedge clock);
        chk("bp_no_extra", {31'd0, reward_valid}, 32'd0);

        // Config write to the arm on its acceptance edge: old threshold (0) is used
        cfg(8'd3, 16'h0000);
        @(negedge clock);
        action_valid = 1'b1; action_data = 8'd3;
        config_write = 1'b1; config_address = 8'd3; config_data = 16'hFFFF;
        @(negedge clock);
        action_valid = 1'b0; config_write = 1'b0;
        tbl[3] = 16'hFFFF;
        @(negedge clock);
        chk("rf_valid", {31'd0, reward_valid}, 32'd1);
        chk("rf_data_old", {16'd0, reward_data}, 32'd0);
        finish_resp(0, 16'd0);
        send(8'd3, e);
        finish_resp(0, e);

        // Write after acceptance does not affect the in-flight transaction
        @(negedge clock);
        action_valid = 1'b1; action_data = 8'd3;
        @(negedge clock);
        action_valid = 1'b0;
        e2 = (m_lfsr < 16'hFFFF) ? 16'd255 : 16'd0;
        config_write = 1'b1; config_address = 8'd3; config_data = 16'h0000;
        @(negedge clock);
        config_write = 1'b0; tbl[3] = 16'h0000;
        chk("late_wr_data", {16'd0, reward_data}, {16'd0, e2});
        finish_resp(0, e2);

        // Reset while in RESPOND: valid and count drop immediately
        send(8'd5, e);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, reward_valid}, 32'd0);
        chk("mid_rst_count", reward_count, 32'd0);
        chk("mid_rst_ready", {31'd0, action_ready}, 32'd0);
        chk("mid_rst_data", {16'd0, reward_data}, 32'd0);
        exp_count = 0;
        @(negedge clock);
        reset = 1'b0;
        send(8'd5, e);
        finish_resp(0, e);

        // Long run on a 50% arm with random reward_ready delay
        cfg(8'd7, 16'h8000);
        base = exp_count;
        for (int n = 0; n < 10000; n++) begin
            send(8'd7, e);
            finish_resp($urandom_range(0, 2), e);
        end
        chk("long_count_exact", reward_count, exp_count);
        chk("long_count_window",
            {31'd0, ((exp_count - base) >= 4700) && ((exp_count - base) <= 5300)}, 32'd1);
        chk("long_dut_window",
            {31'd0, ((int'(reward_count) - base) >= 4700) && ((int'(reward_count) - base) <= 5300)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
